fifo_ptr_ctrl: RTL
==================

# fifo_ptr_ctrl

Pointer and arbitration controller for the shadow-model FIFO. Shares the single RAM write port between two producers with round-robin arbitration and serves one consumer. Owns the (ADDR_WIDTH+1)-bit wrap-bit read and write pointers, issues RAM write/read strobes and addresses, and publishes registered full/empty/almost/count status. Sits between producer/consumer logic and the dual-port FIFO RAM.

## Interface
- ADDR_WIDTH, 10, RAM address width; depth = 2**ADDR_WIDTH
- AFULL_TH, 2**ADDR_WIDTH-4, almost_full asserted when count >= AFULL_TH
- AEMPTY_TH, 4, almost_empty asserted when count <= AEMPTY_TH
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_req  in  2  per-producer write request; data is held by the producer until granted
- wr_gnt  out  2  one-hot grant, combinational, at most one bit set
- wr_sel  out  1  index of the granted producer; steers the RAM write-data mux
- ram_we  out  1  RAM write strobe, equal to |wr_gnt
- ram_waddr  out  ADDR_WIDTH  write address, wptr[ADDR_WIDTH-1:0]
- rd_req  in  1  consumer read request
- ram_re  out  1  RAM read strobe, equal to rd_req & ~empty
- ram_raddr  out  ADDR_WIDTH  read address, rptr[ADDR_WIDTH-1:0]
- rd_valid  out  1  registered; RAM read data is valid in this cycle
- full, empty  out  1 each  registered status
- almost_full, almost_empty  out  1 each  registered threshold status
- count  out  ADDR_WIDTH+1  registered occupancy, 0..2**ADDR_WIDTH
- ovf_err, udf_err  out  1 each  sticky errors: request seen while full/empty

## Operation
- Pointers wptr/rptr are ADDR_WIDTH+1 bits wide and wrap modulo 2**(ADDR_WIDTH+1). The MSB is the lap bit.
- empty = (wptr == rptr). full = MSBs differ and lower bits are equal. Both are computed from the next-state pointers and registered.
- count = wptr - rptr, truncated to ADDR_WIDTH+1 bits.
- Arbitration:
  - Eligible only when ~full.
  - If exactly one wr_req is set, that producer is granted.
  - If both are set, the producer that is not last_gnt is granted. last_gnt updates on every grant.
  - Grant is zero when full.
- Write: wr_gnt != 0 -> RAM write at ram_waddr, and wptr+1 at the edge.
- Read: ram_re -> rptr+1 at the edge, and rd_valid=1 in the next cycle.
- Simultaneous read and write: both are performed. count is unchanged, and full/empty hold.
- No bypass: a write to an empty FIFO is not readable in the same cycle. empty deasserts in the cycle after the write.
- A read and write in the same cycle while full: the read proceeds and the write is refused. The write can be granted the next cycle.
- ovf_err sets when wr_req != 0 and full. udf_err sets when rd_req and empty. Both clear only on reset.
- Reset asserted mid-operation: pointers, count, last_gnt and all registered outputs return to their reset values immediately. Queued contents are discarded.

## Timing
- Reset values:
  - wptr = rptr = 0, count = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0
  - rd_valid = 0, ovf_err = udf_err = 0
  - last_gnt = 1, so producer 0 wins the first tie
- wr_gnt, wr_sel, ram_we, ram_re and the addresses are combinational from current state and requests. There are no combinational loops from grant back to request.
- Status flags and count change one cycle after the causing transfer.
- Read latency: ram_re in cycle N -> rd_valid in cycle N+1. This matches the synchronous-read RAM.
- Sustained throughput: one write and one read per cycle.

## Structure
- A shared package fifo_pkg holds:
  - function ptr_full(wptr, rptr)
  - function ptr_empty(wptr, rptr)
  - localparam-derived DEPTH
  - enum gnt_e {GNT_P0, GNT_P1}
- One sub-module, rr_arb2: a 2-requester round-robin arbiter.
  - Inputs: req[1:0], enable.
  - Outputs: gnt[1:0].
  - Holds the last_gnt register.
- Pointer, flag and error logic stays in the top module.

## Test plan
Directed tests use ADDR_WIDTH=2 (depth 4), AFULL_TH=3, AEMPTY_TH=1.
- Reset, then wr_req=01 for 4 cycles -> wr_gnt=01 each cycle, count 1,2,3,4, full=1 after the 4th edge, almost_full=1 after the 3rd.
- wr_req=11 held with reads active each cycle -> grants alternate 01,10,01,10 starting with 01. count stays steady.
- Full FIFO: wr_req=10 with rd_req=1 in the same cycle -> wr_gnt=00, ram_re=1, ovf_err=1, count=3 next cycle, then the write is granted the following cycle.
- Empty FIFO: rd_req=1 together with wr_req=01 -> ram_re=0, udf_err=1, write granted, empty=0 and count=1 next cycle. rd_valid=0 throughout.
- Wrap-around: perform 9 write/read pairs -> wptr=rptr=9 mod 8 = 1, empty=1, ram_raddr sequence wraps 3 -> 0.
- Assert rst_n low mid-burst at count=2 -> all outputs take their reset values without waiting for a clock edge, and the first tie after release grants producer 0.

Source files
------------

// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared types and pointer helpers for the FIFO pointer controller.
// Latency: none, this file holds only types, constants and pure functions.
// Backpressure: not applicable.
package fifo_pkg;

    // Default RAM address width and the matching FIFO depth.
    localparam int ADDR_WIDTH_DFLT = 10;
    localparam int DEPTH           = 2 ** ADDR_WIDTH_DFLT;

    // Helper functions take pointers zero-extended to this width.
    localparam int PTR_MAX_W = 32;

    // Identity of a write producer.
    typedef enum logic [0:0] {
        GNT_P0 = 1'b0,
        GNT_P1 = 1'b1
    } gnt_e;

    // Full when the lap bits differ and the address bits match.
    // aw is the address width, so the pointers are aw+1 bits wide.
    function automatic logic ptr_full(input logic [PTR_MAX_W-1:0] wptr,
                                      input logic [PTR_MAX_W-1:0] rptr,
                                      input int                   aw);
        logic [PTR_MAX_W-1:0] mask;
        logic [PTR_MAX_W-1:0] diff;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        diff = (wptr ^ rptr) & mask;
        return diff == (32'd1 << aw);
    endfunction

    // Empty when both pointers, lap bit included, are identical.
    function automatic logic ptr_empty(input logic [PTR_MAX_W-1:0] wptr,
                                       input logic [PTR_MAX_W-1:0] rptr,
                                       input int                   aw);
        logic [PTR_MAX_W-1:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        return ((wptr ^ rptr) & mask) == '0;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter that shares the single RAM write port.
// Latency: grant is combinational from req/enable; last_gnt updates at the edge.
// Backpressure: enable low (FIFO full) masks every grant, requesters hold their data.
module rr_arb2
    import fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    gnt_e       r_last_gnt;
    logic [1:0] w_gnt;

    // A lone requester wins outright; on a tie the producer not served last wins.
    always_comb begin
        w_gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = (r_last_gnt == GNT_P0) ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign gnt = w_gnt;

    // Remember who was served; reset to P1 so producer 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= GNT_P1;
        end else if (|w_gnt) begin
            r_last_gnt <= w_gnt[1] ? GNT_P1 : GNT_P0;
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Wrap-bit read/write pointer controller for a dual-port FIFO RAM with two producers.
// Latency: strobes/addresses combinational; status and count registered, rd_valid one cycle after ram_re.
// Backpressure: writes refused while full (grant held low), reads refused while empty.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int AFULL_TH   = 2 ** ADDR_WIDTH - 4,
    parameter int AEMPTY_TH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            wr_req,
    output logic [1:0]            wr_gnt,
    output logic                  wr_sel,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    input  logic                  rd_req,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ovf_err,
    output logic                  udf_err
);

    localparam logic [ADDR_WIDTH:0] C_AFULL  = AFULL_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] C_AEMPTY = AEMPTY_TH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] r_wptr;
    logic [ADDR_WIDTH:0] r_rptr;
    logic [ADDR_WIDTH:0] r_count;
    logic                r_full;
    logic                r_empty;
    logic                r_afull;
    logic                r_aempty;
    logic                r_rd_valid;
    logic                r_ovf;
    logic                r_udf;

    logic [1:0]          w_gnt;
    logic                w_we;
    logic                w_re;
    logic [ADDR_WIDTH:0] w_wptr_nxt;
    logic [ADDR_WIDTH:0] w_rptr_nxt;
    logic [ADDR_WIDTH:0] w_count_nxt;
    logic                w_full_nxt;
    logic                w_empty_nxt;

    // Grant is gated by the registered full flag, so there is no path from grant back to request.
    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (wr_req),
        .enable (~r_full),
        .gnt    (w_gnt)
    );

    assign w_we = |w_gnt;
    assign w_re = rd_req & ~r_empty;

    // Next-state pointers, occupancy and flags; flags are registered from these.
    always_comb begin
        w_wptr_nxt  = r_wptr + {{ADDR_WIDTH{1'b0}}, w_we};
        w_rptr_nxt  = r_rptr + {{ADDR_WIDTH{1'b0}}, w_re};
        w_count_nxt = w_wptr_nxt - w_rptr_nxt;
        w_full_nxt  = ptr_full(32'(w_wptr_nxt), 32'(w_rptr_nxt), ADDR_WIDTH);
        w_empty_nxt = ptr_empty(32'(w_wptr_nxt), 32'(w_rptr_nxt), ADDR_WIDTH);
    end

    // Pointer and status registers; reset discards any queued contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_afull    <= 1'b0;
            r_aempty   <= 1'b1;
            r_rd_valid <= 1'b0;
        end else begin
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_count    <= w_count_nxt;
            r_full     <= w_full_nxt;
            r_empty    <= w_empty_nxt;
            r_afull    <= (w_count_nxt >= C_AFULL);
            r_aempty   <= (w_count_nxt <= C_AEMPTY);
            r_rd_valid <= w_re;
        end
    end

    // Sticky overflow/underflow: any request that meets a full/empty FIFO, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if ((|wr_req) && r_full) r_ovf <= 1'b1;
            if (rd_req && r_empty)   r_udf <= 1'b1;
        end
    end

    assign wr_gnt       = w_gnt;
    assign wr_sel       = w_gnt[1];
    assign ram_we       = w_we;
    assign ram_waddr    = r_wptr[ADDR_WIDTH-1:0];
    assign ram_re       = w_re;
    assign ram_raddr    = r_rptr[ADDR_WIDTH-1:0];
    assign rd_valid     = r_rd_valid;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign count        = r_count;
    assign ovf_err      = r_ovf;
    assign udf_err      = r_udf;

endmodule
